// File: rtl/poli_apb_requester_pkg.sv
// Shared POLI types: register map, register selector, requester FSM states.
package poli_apb_requester_pkg;

  // POLI register window, one 32-bit register per word.
  localparam logic [31:0] BASE_ADDR            = 32'h8003_0000;
  localparam logic [31:0] NAND_NOR_CTRL_ADDR   = BASE_ADDR + 32'h00;
  localparam logic [31:0] NAND_NOR_INPUT_ADDR  = BASE_ADDR + 32'h04;
  localparam logic [31:0] NAND_NOR_OUTPUT_ADDR = BASE_ADDR + 32'h08;
  localparam logic [31:0] XOR_BUF_CTRL_ADDR    = BASE_ADDR + 32'h0C;
  localparam logic [31:0] XOR_BUF_INPUT_ADDR   = BASE_ADDR + 32'h10;
  localparam logic [31:0] XOR_BUF_OUTPUT_ADDR  = BASE_ADDR + 32'h14;
  localparam logic [31:0] CRC_CTRL_ADDR        = BASE_ADDR + 32'h18;
  localparam logic [31:0] CRC_DATA_ADDR        = BASE_ADDR + 32'h1C;
  localparam logic [31:0] CRC_STATUS_ADDR      = BASE_ADDR + 32'h20;
  localparam logic [31:0] CRC_POLY_ADDR        = BASE_ADDR + 32'h24;
  localparam logic [31:0] CRC_OUTPUT_ADDR      = BASE_ADDR + 32'h28;
  localparam logic [31:0] POLI_LAST_ADDR       = CRC_OUTPUT_ADDR;

  typedef enum logic [3:0] {
    NAND_NOR_CTRL   = 4'd0,
    NAND_NOR_INPUT  = 4'd1,
    NAND_NOR_OUTPUT = 4'd2,
    XOR_BUF_CTRL    = 4'd3,
    XOR_BUF_INPUT   = 4'd4,
    XOR_BUF_OUTPUT  = 4'd5,
    CRC_CTRL        = 4'd6,
    CRC_DATA        = 4'd7,
    CRC_STATUS      = 4'd8,
    CRC_POLY        = 4'd9,
    CRC_OUTPUT      = 4'd10,
    BAD_ADDR        = 4'd15
  } regsel_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REJECT = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4
  } poli_apb_state_t;

  // Result and status registers cannot be written by the bus.
  function automatic logic is_read_only(input regsel_t sel);
    logic ro;
    case (sel)
      NAND_NOR_OUTPUT,
      XOR_BUF_OUTPUT,
      CRC_STATUS,
      CRC_OUTPUT: ro = 1'b1;
      default:    ro = 1'b0;
    endcase
    return ro;
  endfunction

endpackage

// File: rtl/poli_addr_decode.sv
// Byte address to POLI register selector; misaligned or unmapped -> BAD_ADDR.
module poli_addr_decode
  import poli_apb_requester_pkg::*;
(
  input  logic [31:0] addr,
  output regsel_t     regsel
);

  // Exact-match decode; every mapped address is word aligned, so any
  // nonzero addr[1:0] falls through to BAD_ADDR as well.
  always_comb begin
    regsel = BAD_ADDR;
    if (addr[1:0] == 2'b00) begin
      case (addr)
        NAND_NOR_CTRL_ADDR:   regsel = NAND_NOR_CTRL;
        NAND_NOR_INPUT_ADDR:  regsel = NAND_NOR_INPUT;
        NAND_NOR_OUTPUT_ADDR: regsel = NAND_NOR_OUTPUT;
        XOR_BUF_CTRL_ADDR:    regsel = XOR_BUF_CTRL;
        XOR_BUF_INPUT_ADDR:   regsel = XOR_BUF_INPUT;
        XOR_BUF_OUTPUT_ADDR:  regsel = XOR_BUF_OUTPUT;
        CRC_CTRL_ADDR:        regsel = CRC_CTRL;
        CRC_DATA_ADDR:        regsel = CRC_DATA;
        CRC_STATUS_ADDR:      regsel = CRC_STATUS;
        CRC_POLY_ADDR:        regsel = CRC_POLY;
        CRC_OUTPUT_ADDR:      regsel = CRC_OUTPUT;
        default:              regsel = BAD_ADDR;
      endcase
    end
  end

endmodule

// File: rtl/poli_apb_requester.sv
// APB3 initiator: valid/ready command port -> single SETUP/ACCESS transfer,
// with wait-state timeout and local rejection of illegal addresses.
module poli_apb_requester
  import poli_apb_requester_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT =
      TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  poli_apb_state_t state_q, state_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  regsel_t req_sel;
  logic    req_reject;
  logic    wait_limit;

  poli_addr_decode u_addr_decode (
    .addr   (req_addr),
    .regsel (req_sel)
  );

  assign req_reject = (req_sel == BAD_ADDR) || (req_write && is_read_only(req_sel));
  // Last permitted wait cycle; never true when the timeout is disabled.
  assign wait_limit = TIMEOUT_EN && (cnt_q == CNT_LIMIT);

  // Next-state, datapath next values and state-decoded outputs.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    psel          = 1'b0;
    penable       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_reject) begin
            // Response fields must already be valid in the REJECT cycle.
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            state_d       = REJECT;
          end else begin
            state_d = SETUP;
          end
        end
      end
      REJECT: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      SETUP: begin
        psel    = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          // pready wins over the timeout on the limit cycle.
          rsp_rdata_d   = (!write_q && !pslverr) ? prdata : '0;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (wait_limit) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus signals only carry the latched command while the slave is selected.
  always_comb begin
    pwrite = psel & write_q;
    paddr  = psel ? addr_q  : '0;
    pwdata = psel ? wdata_q : '0;
  end

  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latches, wait counter and held response fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule
